seg7_scan_decoder: RTL and testbench

- Decoder for the team's active-low 7-segment encoding: seven segment lines plus a one-hot digit strobe in, hex nibble per digit out.
- Samples a multiplexed (scanned) display bus and qualifies each pattern by stability.
- Decodes each qualified pattern back to its 4-bit value and stores it per digit, flagging illegal patterns.
- Sits on the capture/self-check side of the display path: loopback checking of the encoder outputs, or reading an external scanned display.

---
 rtl/seg7_scan_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Captures a scanned active-low 7-segment bus, qualifies each digit pattern by stability and decodes it to a nibble.
// upd fires STABLE_CYCLES+2 cycles after a new pattern reaches the pins; no backpressure (the bus is sampled every cycle).
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [0:6]                seg,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   hex_out,
    output logic [NUM_DIGITS-1:0]     err,
    output logic                      upd,
    output logic [2:0]                upd_idx,
    output logic                      frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_MAX  = 8'hFF;
    // A fresh latch already counts as one stable sample, so a threshold of 1 skips SETTLE.
    localparam state_t RELATCH_NEXT = (STABLE_CYCLES <= 1) ? COMMIT : SETTLE;
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

    logic [6:0]              s_seg_q, s_seg_d;
    logic [NUM_DIGITS-1:0]   s_sel_q, s_sel_d;
    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [6:0]              ref_seg_q, ref_seg_d;
    logic [NUM_DIGITS-1:0]   ref_sel_q, ref_sel_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    upd_q, upd_d;
    logic [2:0]              upd_idx_q, upd_idx_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;

    logic                    sel_vld;
    logic                    same;
    logic [7:0]              cnt_inc;
    logic [2:0]              sel_idx;
    logic [4:0]              dec;
    logic [NUM_DIGITS-1:0]   seen_nxt;

    // Returns {illegal, nibble}; the pattern is read with g as the MSB.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   return 5'h00;
            7'h79:   return 5'h01;
            7'h24:   return 5'h02;
            7'h30:   return 5'h03;
            7'h19:   return 5'h04;
            7'h12:   return 5'h05;
            7'h02:   return 5'h06;
            7'h78:   return 5'h07;
            7'h00:   return 5'h08;
            7'h18:   return 5'h09;
            7'h08:   return 5'h0A;
            7'h03:   return 5'h0B;
            7'h46:   return 5'h0C;
            7'h21:   return 5'h0D;
            7'h06:   return 5'h0E;
            7'h0E:   return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    assign s_seg_d  = seg;
    assign s_sel_d  = dig_sel;
    assign sel_vld  = $onehot(s_sel_q);
    assign same     = (s_seg_q == ref_seg_q) && (s_sel_q == ref_sel_q);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    assign dec      = decode(ref_seg_q);
    assign seen_nxt = seen_q | ref_sel_q;

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ref_sel_q[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ref_seg_d    = ref_seg_q;
        ref_sel_d    = ref_sel_q;
        hex_d        = hex_q;
        err_d        = err_q;
        upd_d        = 1'b0;
        upd_idx_d    = upd_idx_q;
        frame_done_d = 1'b0;
        seen_d       = seen_q;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (sel_vld) begin
                    ref_seg_d = s_seg_q;
                    ref_sel_d = s_sel_q;
                    cnt_d     = 8'd1;
                    state_d   = RELATCH_NEXT;
                end
            end
            SETTLE: begin
                if (!sel_vld) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (same) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= STABLE_N) begin
                        state_d = COMMIT;
                    end
                end else begin
                    ref_seg_d = s_seg_q;
                    ref_sel_d = s_sel_q;
                    cnt_d     = 8'd1;
                    state_d   = RELATCH_NEXT;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (ref_sel_q[i]) begin
                        hex_d[4*i +: 4] = dec[3:0];
                        err_d[i]        = dec[4];
                    end
                end
                upd_d     = 1'b1;
                upd_idx_d = sel_idx;
                // Completing the frame clears the mask in the same cycle so the next frame starts clean.
                if (seen_nxt == ALL_SEEN) begin
                    frame_done_d = 1'b1;
                    seen_d       = '0;
                end else begin
                    seen_d = seen_nxt;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (!same) begin
                    if (!sel_vld) begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end else begin
                        ref_seg_d = s_seg_q;
                        ref_sel_d = s_sel_q;
                        cnt_d     = 8'd1;
                        state_d   = RELATCH_NEXT;
                    end
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_seg_q      <= 7'h7F;
            s_sel_q      <= '0;
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            ref_seg_q    <= 7'h7F;
            ref_sel_q    <= '0;
            hex_q        <= '0;
            err_q        <= '0;
            upd_q        <= 1'b0;
            upd_idx_q    <= 3'd0;
            frame_done_q <= 1'b0;
            seen_q       <= '0;
        end else begin
            s_seg_q      <= s_seg_d;
            s_sel_q      <= s_sel_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_seg_q    <= ref_seg_d;
            ref_sel_q    <= ref_sel_d;
            hex_q        <= hex_d;
            err_q        <= err_d;
            upd_q        <= upd_d;
            upd_idx_q    <= upd_idx_d;
            frame_done_q <= frame_done_d;
            seen_q       <= seen_d;
        end
    end

    assign hex_out    = hex_q;
    assign err        = err_q;
    assign upd        = upd_q;
    assign upd_idx    = upd_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench: drives one scanned bus into a STABLE_CYCLES=4 and a STABLE_CYCLES=1 decoder side by side.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:6]  seg;
    logic [3:0]  dig_sel;

    logic [15:0] hex0, hex1;
    logic [3:0]  err0, err1;
    logic        upd0, upd1;
    logic [2:0]  idx0, idx1;
    logic        fd0, fd1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int upd_n0 = 0, upd_c0 = 0, fd_n0 = 0, fd_c0 = 0;
    int upd_n1 = 0, upd_c1 = 0, fd_n1 = 0, fd_c1 = 0;
    logic [2:0] last_idx0 = 3'd0;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset), .seg(seg), .dig_sel(dig_sel),
        .hex_out(hex0), .err(err0), .upd(upd0), .upd_idx(idx0), .frame_done(fd0)
    );

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .seg(seg), .dig_sel(dig_sel),
        .hex_out(hex1), .err(err1), .upd(upd1), .upd_idx(idx1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (upd0) begin
            upd_n0    <= upd_n0 + 1;
            upd_c0    <= cyc;
            last_idx0 <= idx0;
        end
        if (fd0) begin
            fd_n0 <= fd_n0 + 1;
            fd_c0 <= cyc;
        end
        if (upd1) begin
            upd_n1 <= upd_n1 + 1;
            upd_c1 <= cyc;
        end
        if (fd1) begin
            fd_n1 <= fd_n1 + 1;
            fd_c1 <= cyc;
        end
    end

    typedef struct {
        logic [6:0] pat;
        logic [3:0] nib;
        logic       bad;
    } vec_t;

    vec_t tbl [18];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] p, input logic [3:0] s);
        seg     = p;
        dig_sel = s;
    endtask

    int k, n0, n1, f0, f1;

    initial begin
        tbl[0]  = '{7'h40, 4'h0, 1'b0};
        tbl[1]  = '{7'h79, 4'h1, 1'b0};
        tbl[2]  = '{7'h24, 4'h2, 1'b0};
        tbl[3]  = '{7'h30, 4'h3, 1'b0};
        tbl[4]  = '{7'h19, 4'h4, 1'b0};
        tbl[5]  = '{7'h12, 4'h5, 1'b0};
        tbl[6]  = '{7'h02, 4'h6, 1'b0};
        tbl[7]  = '{7'h78, 4'h7, 1'b0};
        tbl[8]  = '{7'h00, 4'h8, 1'b0};
        tbl[9]  = '{7'h18, 4'h9, 1'b0};
        tbl[10] = '{7'h08, 4'hA, 1'b0};
        tbl[11] = '{7'h03, 4'hB, 1'b0};
        tbl[12] = '{7'h7F, 4'h0, 1'b1};
        tbl[13] = '{7'h46, 4'hC, 1'b0};
        tbl[14] = '{7'h21, 4'hD, 1'b0};
        tbl[15] = '{7'h01, 4'h0, 1'b1};
        tbl[16] = '{7'h06, 4'hE, 1'b0};
        tbl[17] = '{7'h0E, 4'hF, 1'b0};

        reset = 1'b1;
        drive(7'h7F, 4'b0000);
        tick(3);
        check("rst_hex", 32'(hex0), 32'h0);
        check("rst_err", 32'(err0), 32'h0);
        check("rst_upd", 32'(upd0), 32'h0);
        check("rst_idx", 32'(idx0), 32'h0);
        check("rst_fd",  32'(fd0),  32'h0);
        reset = 1'b0;
        tick(3);

        // Legal decode: digit 1, pattern 2
        k = cyc; n0 = upd_n0; n1 = upd_n1;
        drive(7'h24, 4'b0010);
        tick(10);
        check("dec_upd_cnt", 32'(upd_n0 - n0), 32'd1);
        check("dec_upd_cyc", 32'(upd_c0 - k), 32'd6);
        check("dec_idx",     32'(last_idx0), 32'd1);
        check("dec_nib",     32'(hex0[7:4]), 32'h2);
        check("dec_err",     32'(err0[1]), 32'h0);
        check("dec1_upd_cnt", 32'(upd_n1 - n1), 32'd1);
        check("dec1_upd_cyc", 32'(upd_c1 - k), 32'd3);

        // Glitch rejection on digit 0
        drive(7'h7F, 4'b0000);
        tick(3);
        k = cyc; n0 = upd_n0;
        drive(7'h30, 4'b0001);
        tick(3);
        drive(7'h79, 4'b0001);
        tick(3);
        drive(7'h30, 4'b0001);
        tick(6);
        drive(7'h7F, 4'b0000);
        tick(3);
        check("glitch_upd_cnt", 32'(upd_n0 - n0), 32'd1);
        check("glitch_upd_cyc", 32'(upd_c0 - k), 32'd12);
        check("glitch_nib",     32'(hex0[3:0]), 32'h3);

        // Legal then illegal on digit 2, then an invalid two-hot select
        drive(7'h00, 4'b0100);
        tick(8);
        check("d2_legal_nib", 32'(hex0[11:8]), 32'h8);
        check("d2_legal_err", 32'(err0[2]), 32'h0);
        drive(7'h7F, 4'b0100);
        tick(8);
        check("d2_bad_nib", 32'(hex0[11:8]), 32'h0);
        check("d2_bad_err", 32'(err0[2]), 32'h1);
        check("d2_keep_d1", 32'(hex0[7:4]), 32'h2);
        n0 = upd_n0; n1 = upd_n1;
        drive(7'h24, 4'b0110);
        tick(20);
        check("twohot_upd0", 32'(upd_n0 - n0), 32'd0);
        check("twohot_upd1", 32'(upd_n1 - n1), 32'd0);

        // Asynchronous reset while digit 1 is settling
        drive(7'h19, 4'b0010);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hex",  32'(hex0), 32'h0);
        check("arst_err",  32'(err0), 32'h0);
        check("arst_idx",  32'(idx0), 32'h0);
        check("arst_upd",  32'(upd0), 32'h0);
        check("arst_fd",   32'(fd0),  32'h0);
        check("arst_hex1", 32'(hex1), 32'h0);
        check("arst_upd1", 32'(upd1), 32'h0);
        n0 = upd_n0; n1 = upd_n1;
        tick(2);
        reset = 1'b0;
        drive(7'h7F, 4'b0000);
        tick(4);
        check("arst_no_commit0", 32'(upd_n0 - n0), 32'd0);
        check("arst_no_commit1", 32'(upd_n1 - n1), 32'd0);
        check("arst_hex_after",  32'(hex0), 32'h0);

        // Frame: A, b, C, d on digits 0..3
        n0 = upd_n0; n1 = upd_n1; f0 = fd_n0; f1 = fd_n1;
        drive(7'h08, 4'b0001); tick(6);
        drive(7'h03, 4'b0010); tick(6);
        drive(7'h46, 4'b0100); tick(6);
        drive(7'h21, 4'b1000); tick(6);
        drive(7'h7F, 4'b0000); tick(3);
        check("frame_upd_cnt", 32'(upd_n0 - n0), 32'd4);
        check("frame_fd_cnt",  32'(fd_n0 - f0), 32'd1);
        check("frame_fd_cyc",  32'(fd_c0), 32'(upd_c0));
        check("frame_idx",     32'(last_idx0), 32'd3);
        check("frame_hex",     32'(hex0), 32'hDCBA);
        check("frame_err",     32'(err0), 32'h0);
        check("frame1_upd_cnt", 32'(upd_n1 - n1), 32'd4);
        check("frame1_fd_cnt",  32'(fd_n1 - f1), 32'd1);
        check("frame1_fd_cyc",  32'(fd_c1), 32'(upd_c1));
        check("frame1_hex",     32'(hex1), 32'hDCBA);

        // Full pattern sweep through digit 3
        for (int i = 0; i < 18; i++) begin
            k = cyc; n0 = upd_n0; n1 = upd_n1;
            drive(tbl[i].pat, 4'b1000);
            tick(8);
            check($sformatf("tbl%0d_cnt", i),  32'(upd_n0 - n0), 32'd1);
            check($sformatf("tbl%0d_cyc", i),  32'(upd_c0 - k), 32'd6);
            check($sformatf("tbl%0d_nib", i),  32'(hex0[15:12]), 32'(tbl[i].nib));
            check($sformatf("tbl%0d_err", i),  32'(err0[3]), 32'(tbl[i].bad));
            check($sformatf("tbl%0d_cnt1", i), 32'(upd_n1 - n1), 32'd1);
            check($sformatf("tbl%0d_cyc1", i), 32'(upd_c1 - k), 32'd3);
            check($sformatf("tbl%0d_nib1", i), 32'(hex1[15:12]), 32'(tbl[i].nib));
        end
        check("sweep_keep_low", 32'(hex0[11:0]), 32'hCBA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
